block_sram_writer: RTL and testbench

- Downstream stage of the 8x8 clamped-pixel block buffer.
- On a start pulse (driven by the buffer controller's start_part2), it reads the 64 buffered 8-bit pixels row by row.
- Packs two horizontally adjacent pixels into one 16-bit SRAM word and writes the 32 words into frame SRAM at the block's position.
- Raises done when the last word has been accepted.

---
 rtl/block_sram_writer_pkg.sv | 18 +
 rtl/block_sram_writer_if.sv | 33 +++
 rtl/block_sram_writer_counterr.sv | 29 ++
 rtl/block_sram_writer.sv | 165 ++++++++++++++++
 tb/tb_block_sram_writer.sv | 392 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/block_sram_writer_pkg.sv
// Shared types and constants for the 8x8 block-to-SRAM writer.
package block_sram_writer_pkg;

  localparam int BLK_N           = 8;
  localparam int PAIRS_PER_ROW   = 4;
  localparam int PIX_W           = 8;
  localparam int WORDS_PER_BLOCK = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH0 = 3'd1,
    FETCH1 = 3'd2,
    PACK   = 3'd3,
    WRITE  = 3'd4,
    DONE   = 3'd5
  } state_e;

endpackage

// File: rtl/block_sram_writer_if.sv
// Start/buffer-read/SRAM-write signal bundle of the block writer.
// master = the writer itself, slave = its environment.
interface block_sram_writer_if
  import block_sram_writer_pkg::*;
#(
  parameter int AW = 18,
  parameter int DW = 16
) ();

  logic             start;
  logic [AW-1:0]    base_addr;
  logic             rd_en;
  logic [2:0]       rd_row;
  logic [2:0]       rd_col;
  logic [PIX_W-1:0] rd_data;
  logic             sram_we;
  logic [AW-1:0]    sram_addr;
  logic [DW-1:0]    sram_wdata;
  logic             sram_ready;
  logic             busy;
  logic             done;

  modport master (
    input  start, base_addr, rd_data, sram_ready,
    output rd_en, rd_row, rd_col, sram_we, sram_addr, sram_wdata, busy, done
  );

  modport slave (
    output start, base_addr, rd_data, sram_ready,
    input  rd_en, rd_row, rd_col, sram_we, sram_addr, sram_wdata, busy, done
  );

endinterface

// File: rtl/block_sram_writer_counterr.sv
// counterr: generic up-counter with synchronous clear (clear wins over enable).
module counterr #(
  parameter int SIZE = 3
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            clr_i,
  input  logic            en_i,
  output logic [SIZE-1:0] count_o
);

  logic [SIZE-1:0] count_q;

  // Count register: clear has priority, wraps naturally at 2^SIZE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_q + {{(SIZE-1){1'b0}}, 1'b1};
    end else begin
      count_q <= count_q;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/block_sram_writer.sv
// block_sram_writer: reads a buffered 8x8 pixel block row by row, packs each
// horizontal pixel pair (even column in the high byte) into one SRAM word and
// writes the 32 words to frame SRAM starting at the sampled base address.
// All interface outputs are registered so an async reset clears them at once.
module block_sram_writer
  import block_sram_writer_pkg::*;
#(
  parameter int AW         = 18,
  parameter int DW         = 16,
  parameter int ROW_STRIDE = 160
) (
  input  logic                clock,
  input  logic                reset,
  block_sram_writer_if.master bus
);

  localparam logic [2:0]    LAST_ROW  = 3'(BLK_N - 1);
  localparam logic [1:0]    LAST_PAIR = 2'(PAIRS_PER_ROW - 1);
  localparam logic [AW-1:0] STRIDE    = AW'(ROW_STRIDE);

  state_e        state_q, state_d;
  logic          r_clr, r_en, k_clr, k_en;
  logic [2:0]    r_cnt;
  logic [1:0]    k_cnt;
  logic [AW-1:0] row_base_q, row_base_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          rd_en_q, rd_en_d;
  logic [2:0]    rd_row_q, rd_row_d;
  logic [2:0]    rd_col_q, rd_col_d;
  logic          we_q, we_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  counterr #(.SIZE(3)) u_row_cnt (
    .clock   (clock),
    .reset   (reset),
    .clr_i   (r_clr),
    .en_i    (r_en),
    .count_o (r_cnt)
  );

  counterr #(.SIZE(2)) u_pair_cnt (
    .clock   (clock),
    .reset   (reset),
    .clr_i   (k_clr),
    .en_i    (k_en),
    .count_o (k_cnt)
  );

  // Next state plus next values of every registered output; read strobes and
  // indices are produced for the state being entered.
  always_comb begin
    state_d    = state_q;
    r_clr      = 1'b0;
    r_en       = 1'b0;
    k_clr      = 1'b0;
    k_en       = 1'b0;
    row_base_d = row_base_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_en_d    = 1'b0;
    rd_row_d   = 3'd0;
    rd_col_d   = 3'd0;
    we_d       = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d    = FETCH0;
          row_base_d = bus.base_addr;
          r_clr      = 1'b1;
          k_clr      = 1'b1;
          rd_en_d    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH0: begin
        state_d  = FETCH1;
        rd_en_d  = 1'b1;
        rd_row_d = r_cnt;
        rd_col_d = {k_cnt, 1'b1};
      end
      FETCH1: begin
        state_d = PACK;
        wdata_d = {bus.rd_data, wdata_q[PIX_W-1:0]};
      end
      PACK: begin
        state_d = WRITE;
        wdata_d = {wdata_q[DW-1:PIX_W], bus.rd_data};
        addr_d  = row_base_q + {{(AW-2){1'b0}}, k_cnt};
        we_d    = 1'b1;
      end
      WRITE: begin
        if (bus.sram_ready) begin
          if (k_cnt != LAST_PAIR) begin
            k_en     = 1'b1;
            state_d  = FETCH0;
            rd_en_d  = 1'b1;
            rd_row_d = r_cnt;
            rd_col_d = {k_cnt + 2'd1, 1'b0};
          end else if (r_cnt != LAST_ROW) begin
            r_en       = 1'b1;
            k_clr      = 1'b1;
            row_base_d = row_base_q + STRIDE;
            state_d    = FETCH0;
            rd_en_d    = 1'b1;
            rd_row_d   = r_cnt + 3'd1;
            rd_col_d   = 3'd0;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end else begin
          we_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset abandons any block in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      row_base_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_en_q    <= 1'b0;
      rd_row_q   <= 3'd0;
      rd_col_q   <= 3'd0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_en_q    <= rd_en_d;
      rd_row_q   <= rd_row_d;
      rd_col_q   <= rd_col_d;
      we_q       <= we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.rd_en      = rd_en_q;
  assign bus.rd_row     = rd_row_q;
  assign bus.rd_col     = rd_col_q;
  assign bus.sram_we    = we_q;
  assign bus.sram_addr  = addr_q;
  assign bus.sram_wdata = wdata_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_block_sram_writer.sv
// Bench for block_sram_writer: buffer model pixel(i,j) = (8i+j) ^ pat, a
// scoreboard of expected SRAM writes, optional SRAM backpressure.
module tb_block_sram_writer;
  import block_sram_writer_pkg::*;

  localparam int AW  = 18;
  localparam int DW  = 16;
  localparam int RS  = 160;
  localparam int WPB = WORDS_PER_BLOCK;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  block_sram_writer_if #(.AW(AW), .DW(DW)) bus ();

  block_sram_writer #(.AW(AW), .DW(DW), .ROW_STRIDE(RS)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [7:0] pat = 8'h00;

  function automatic logic [7:0] pix(input int i, input int j, input logic [7:0] p);
    return 8'(8 * i + j) ^ p;
  endfunction

  // Buffer model: data valid one cycle after the read strobe.
  always @(posedge clock or posedge reset) begin
    if (reset) bus.rd_data <= 8'h00;
    else if (bus.rd_en) bus.rd_data <= pix(int'(bus.rd_row), int'(bus.rd_col), pat);
  end

  int         n_checks  = 0;
  int         n_fail    = 0;
  wr_t        sb[$];
  wr_t        log_q[$];
  int         wr_cnt    = 0;
  int         done_cnt  = 0;
  int         done_cyc  = 0;
  int         start_cyc = 0;
  int         stall_cnt = 0;
  bit         stall_en  = 1'b0;
  logic [AW-1:0] held_a;
  logic [DW-1:0] held_d;

  // One cycle: sample at the falling edge, drive sram_ready, score writes.
  task automatic step();
    wr_t e;
    wr_t ex;
    @(negedge clock);
    if (reset) begin
      stall_cnt      = 0;
      bus.sram_ready = 1'b0;
    end else if (bus.sram_we) begin
      if (stall_cnt > 0) begin
        n_checks++;
        if (bus.sram_addr !== held_a || bus.sram_wdata !== held_d) begin
          n_fail++;
          $display("FAIL stall_stable: addr=%h data=%h, required addr=%h data=%h",
                   bus.sram_addr, bus.sram_wdata, held_a, held_d);
        end
      end else begin
        held_a = bus.sram_addr;
        held_d = bus.sram_wdata;
      end
      if (stall_en && stall_cnt < 3) begin
        stall_cnt++;
        bus.sram_ready = 1'b0;
      end else begin
        bus.sram_ready = 1'b1;
        stall_cnt      = 0;
        e.a = bus.sram_addr;
        e.d = bus.sram_wdata;
        log_q.push_back(e);
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write: addr=%h data=%h, required no write", e.a, e.d);
        end else begin
          ex = sb.pop_front();
          if (e !== ex) begin
            n_fail++;
            $display("FAIL write_%0d: addr=%h data=%h, required addr=%h data=%h",
                     wr_cnt, e.a, e.d, ex.a, ex.d);
          end
        end
        wr_cnt++;
      end
    end else begin
      bus.sram_ready = !stall_en;
    end
    if (bus.done) begin
      done_cnt++;
      done_cyc = cyc - start_cyc + 1;
    end
  endtask

  task automatic push_block(input logic [AW-1:0] base, input logic [7:0] p);
    wr_t e;
    logic [31:0] t;
    for (int n = 0; n < WPB; n++) begin
      t   = 32'(base) + 32'((n / 4) * RS) + 32'(n % 4);
      e.a = t[AW-1:0];
      e.d = {pix(n / 4, 2 * (n % 4), p), pix(n / 4, 2 * (n % 4) + 1, p)};
      sb.push_back(e);
    end
  endtask

  task automatic pulse_start(input logic [AW-1:0] base);
    step();
    bus.base_addr = base;
    bus.start     = 1'b1;
    @(posedge clock);
    #1;
    start_cyc = cyc;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int exp_cyc, input string name);
    int d0 = done_cnt;
    bit seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      step();
      if (done_cnt != d0) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s_done_seen: no done within 2000 cycles, required done", name);
    end else begin
      n_checks++;
      if (done_cyc != exp_cyc) begin
        n_fail++;
        $display("FAIL %s_done_cycle: got %0d, required %0d", name, done_cyc, exp_cyc);
      end
    end
    step();
    n_checks++;
    if (done_cnt != d0 + 1 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_done_pulse: %0d high cycles, required 1", name, done_cnt - d0);
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_busy_fall: busy=%b, required 0", name, bus.busy);
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_missing_writes: %0d left, required 0", name, sb.size());
    end
  endtask

  task automatic check_outputs_zero(input string name);
    logic [43:0] o;
    o = {bus.rd_en, bus.rd_row, bus.rd_col, bus.sram_we, bus.sram_addr,
         bus.sram_wdata, bus.busy, bus.done};
    n_checks++;
    if (o !== 44'd0) begin
      n_fail++;
      $display("FAIL %s: outputs=%h, required 0", name, o);
    end
  endtask

  task automatic test_reset();
    bus.start     = 1'b0;
    bus.base_addr = '0;
    reset         = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check_outputs_zero("reset_outputs");
    step();
    reset = 1'b0;
    repeat (3) step();
    n_checks++;
    if (bus.busy !== 1'b0 || wr_cnt != 0) begin
      n_fail++;
      $display("FAIL idle_quiet: busy=%b writes=%0d, required 0/0", bus.busy, wr_cnt);
    end
  endtask

  task automatic test_basic();
    int w0 = wr_cnt;
    int b0 = log_q.size();
    wr_t e;
    pat = 8'h00;
    push_block(18'h00000, pat);
    pulse_start(18'h00000);
    wait_done(129, "basic");
    n_checks++;
    if (wr_cnt - w0 != 32) begin
      n_fail++;
      $display("FAIL basic_count: %0d writes, required 32", wr_cnt - w0);
    end
    n_checks++;
    if (log_q.size() > b0 + 31) begin
      e = log_q[b0 + 5];
      if (e.a !== 18'd161 || e.d !== 16'h0A0B) begin
        n_fail++;
        $display("FAIL basic_write5: addr=%0d data=%h, required 161/0a0b", e.a, e.d);
      end
      e = log_q[b0 + 31];
      n_checks++;
      if (e.a !== 18'd1123 || e.d !== 16'h3E3F) begin
        n_fail++;
        $display("FAIL basic_write31: addr=%0d data=%h, required 1123/3e3f", e.a, e.d);
      end
    end else begin
      n_fail++;
      $display("FAIL basic_log: %0d writes logged, required 32", log_q.size() - b0);
    end
  endtask

  task automatic test_backpressure();
    int w0 = wr_cnt;
    stall_en = 1'b1;
    pat      = 8'h5A;
    push_block(18'h00400, pat);
    pulse_start(18'h00400);
    wait_done(225, "stall");
    stall_en = 1'b0;
    n_checks++;
    if (wr_cnt - w0 != 32) begin
      n_fail++;
      $display("FAIL stall_count: %0d writes, required 32", wr_cnt - w0);
    end
  endtask

  task automatic test_start_ignored();
    int w0 = wr_cnt;
    int d0 = done_cnt;
    int c;
    pat = 8'hC3;
    push_block(18'h00100, pat);
    pulse_start(18'h00100);
    for (int i = 0; i < 200; i++) begin
      step();
      c = cyc - start_cyc + 1;
      bus.start = (c == 10 || c == 129);
      if (c == 10) bus.base_addr = 18'h03000;
      if (c == 20) begin
        n_checks++;
        if (bus.busy !== 1'b1) begin
          n_fail++;
          $display("FAIL ign_busy_mid: busy=%b, required 1", bus.busy);
        end
      end
      if (c == 129) begin
        n_checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b1) begin
          n_fail++;
          $display("FAIL ign_done_cycle: busy=%b done=%b, required 1/1", bus.busy, bus.done);
        end
      end
      if (c == 130) begin
        n_checks++;
        if (bus.busy !== 1'b0 || wr_cnt - w0 != 32 || done_cnt - d0 != 1) begin
          n_fail++;
          $display("FAIL ign_after: busy=%b writes=%0d dones=%0d, required 0/32/1",
                   bus.busy, wr_cnt - w0, done_cnt - d0);
        end
      end
      if (c == 131) begin
        push_block(18'h00200, pat);
        bus.base_addr = 18'h00200;
        bus.start     = 1'b1;
        @(posedge clock);
        #1;
        start_cyc = cyc;
        bus.start = 1'b0;
        break;
      end
    end
    wait_done(129, "relaunch");
    n_checks++;
    if (wr_cnt - w0 != 64) begin
      n_fail++;
      $display("FAIL relaunch_count: %0d writes, required 64", wr_cnt - w0);
    end
  endtask

  task automatic test_reset_mid();
    int  w0 = wr_cnt;
    int  b1;
    bit  found = 1'b0;
    wr_t e;
    stall_en = 1'b1;
    pat      = 8'h99;
    push_block(18'h01000, pat);
    pulse_start(18'h01000);
    for (int i = 0; i < 1000 && !found; i++) begin
      step();
      if (wr_cnt - w0 == 17 && stall_cnt == 1) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL rmid_reach_word17: not reached, required WRITE of word 17");
    end
    #2;
    reset = 1'b1;
    #1;
    check_outputs_zero("rmid_async_outputs");
    sb.delete();
    repeat (2) step();
    reset    = 1'b0;
    stall_en = 1'b0;
    repeat (20) step();
    n_checks++;
    if (wr_cnt - w0 != 17 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_quiet: writes=%0d busy=%b, required 17/0", wr_cnt - w0, bus.busy);
    end
    b1  = log_q.size();
    pat = 8'h66;
    push_block(18'h01000, pat);
    pulse_start(18'h01000);
    wait_done(129, "rmid_restart");
    n_checks++;
    if (wr_cnt - w0 != 49) begin
      n_fail++;
      $display("FAIL rmid_count: %0d writes, required 49", wr_cnt - w0);
    end
    n_checks++;
    if (log_q.size() > b1) begin
      e = log_q[b1];
      if (e.a !== 18'h01000 || e.d !== 16'h6667) begin
        n_fail++;
        $display("FAIL rmid_first: addr=%h data=%h, required 01000/6667", e.a, e.d);
      end
    end else begin
      n_fail++;
      $display("FAIL rmid_first: no write logged, required word 0");
    end
  endtask

  task automatic test_wrap();
    int  b0 = log_q.size();
    wr_t e;
    pat = 8'hF0;
    push_block(18'h3FFF6, pat);
    pulse_start(18'h3FFF6);
    wait_done(129, "wrap");
    n_checks++;
    if (log_q.size() > b0 + 4) begin
      e = log_q[b0];
      if (e.a !== 18'h3FFF6) begin
        n_fail++;
        $display("FAIL wrap_word0: addr=%h, required 3fff6", e.a);
      end
      e = log_q[b0 + 4];
      n_checks++;
      if (e.a !== 18'h00096) begin
        n_fail++;
        $display("FAIL wrap_word4: addr=%h, required 00096", e.a);
      end
    end else begin
      n_fail++;
      $display("FAIL wrap_log: %0d writes logged, required 32", log_q.size() - b0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_start_ignored();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
